// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program-memory and issue-side bus of the instruction sequencer
// master = sequencer side, slave = memory/downstream side
interface instr_sequencer_if #(
  parameter int WIDTH_OPCODE = 4,
  parameter int WIDTH_INSTR  = 16,
  parameter int WIDTH_ADDR   = 8
);
  logic                                mem_req;
  logic [WIDTH_ADDR-1:0]               mem_addr;
  logic [WIDTH_INSTR-1:0]              mem_data;
  logic                                mem_valid;
  logic [WIDTH_OPCODE-1:0]             opcode;
  logic [WIDTH_INSTR-WIDTH_OPCODE-1:0] operand;
  logic                                op_valid;
  logic                                stall;
  logic                                branch_en;
  logic [WIDTH_ADDR-1:0]               branch_target;

  modport master (
    output mem_req, mem_addr, opcode, operand, op_valid,
    input  mem_data, mem_valid, stall, branch_en, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, opcode, operand, op_valid,
    output mem_data, mem_valid, stall, branch_en, branch_target
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/issue sequencer: IDLE, FETCH, WAIT, ISSUE, HALT
// Optional memory fetch timeout enabled by defining SEQ_FETCH_TIMEOUT_EN.
module instr_sequencer #(
  parameter int                      WIDTH_OPCODE = 4,
  parameter int                      WIDTH_INSTR  = 16,
  parameter int                      WIDTH_ADDR   = 8,
  parameter logic [WIDTH_OPCODE-1:0] HALT_OPCODE  = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_sequencer_if.master     bus,
  output logic [WIDTH_ADDR-1:0] pc,
  output logic                  halted,
  output logic                  fetch_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH_INSTR-1:0] ir;
  logic                   issue_fire;
  logic                   is_halt_word;

  assign is_halt_word = (bus.mem_data[WIDTH_INSTR-1 -: WIDTH_OPCODE] == HALT_OPCODE);

`ifdef SEQ_FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       timeout_hit;
  logic       fetch_error_q;
`endif

  always_comb begin
    state_nxt    = state;
    issue_fire   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.op_valid = 1'b0;
    halted       = 1'b0;
`ifdef SEQ_FETCH_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        bus.mem_req = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // A halt word is latched but routed straight to HALT so it never issues.
        if (bus.mem_valid) begin
          state_nxt = is_halt_word ? HALT : ISSUE;
        end
`ifdef SEQ_FETCH_TIMEOUT_EN
        else if (wait_cnt == 4'd14) begin
          state_nxt   = HALT;
          timeout_hit = 1'b1;
        end
`endif
      end
      ISSUE: begin
        bus.op_valid = 1'b1;
        if (!bus.stall) begin
          issue_fire = 1'b1;
          state_nxt  = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_addr = pc;
  assign bus.opcode   = ir[WIDTH_INSTR-1 -: WIDTH_OPCODE];
  assign bus.operand  = ir[WIDTH_INSTR-WIDTH_OPCODE-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (issue_fire) begin
        pc <= bus.branch_en ? bus.branch_target : pc + WIDTH_ADDR'(1);
      end
      if (state == WAIT && bus.mem_valid) begin
        ir <= bus.mem_data;
      end
    end
  end

`ifdef SEQ_FETCH_TIMEOUT_EN
  // Counter is zeroed while in FETCH so it starts at 0 on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt      <= 4'd0;
      fetch_error_q <= 1'b0;
    end else begin
      if (state == FETCH) begin
        wait_cnt <= 4'd0;
      end else if (state == WAIT && !bus.mem_valid) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (timeout_hit) begin
        fetch_error_q <= 1'b1;
      end
    end
  end

  assign fetch_error = fetch_error_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameters SHALL be: WIDTH_OPCODE 4 (opcode field width); WIDTH_INSTR 16 (instruction word width); WIDTH_ADDR 8 (program address width); HALT_OPCODE 4'hF (stop instruction).
REQ-002 Clk  input  1  single clock, all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  begin fetching at current Pc; sampled only in IDLE.
REQ-005 Stall  input  1  downstream not ready; holds the issued instruction.
REQ-006 BranchEn  input  1  load BranchTarget into Pc on the issue handshake.
REQ-007 BranchTarget  input  WIDTH_ADDR  branch destination address.
REQ-008 MemReq  output  1  single-cycle program memory read request.
REQ-009 MemAddr  output  WIDTH_ADDR  read address, equals Pc.
REQ-010 MemData  input  WIDTH_INSTR  returned instruction word.
REQ-011 MemValid  input  1  MemData valid this cycle.
REQ-012 Opcode  output  WIDTH_OPCODE  MemData[15:12] of the issued instruction; drives the control decoder Opcode input.
REQ-013 Operand  output  WIDTH_INSTR-WIDTH_OPCODE  MemData[11:0] of the issued instruction.
REQ-014 OpValid  output  1  Opcode/Operand valid.
REQ-015 Pc  output  WIDTH_ADDR  address of the instruction being fetched or issued.
REQ-016 Halted  output  1  sequencer stopped on HALT_OPCODE or timeout.
REQ-017 FetchError  output  1  memory timeout flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, FETCH, WAIT, ISSUE, HALT.
REQ-019 IDLE: Start=1 -> FETCH next cycle; else stay.
REQ-020 FETCH: MemReq=1 for exactly one cycle with MemAddr=Pc; -> WAIT unconditionally.
REQ-021 WAIT: MemValid=1 -> latch MemData into the instruction register; if MemData[15:12]==HALT_OPCODE -> HALT, else -> ISSUE; MemValid=0 -> stay.
REQ-022 ISSUE: OpValid=1 with Opcode/Operand from the instruction register; Stall=1 -> stay, outputs stable.
REQ-023 ISSUE with Stall=0 (issue handshake): Pc <= BranchEn ? BranchTarget : Pc+1; -> FETCH.
REQ-024 Pc+1 SHALL wrap modulo 2^WIDTH_ADDR (8'hFF -> 8'h00).
REQ-025 Fetch-to-issue latency: OpValid rises the cycle after MemValid; the next MemReq follows one cycle after the handshake.
REQ-026 HALT: Halted=1, OpValid=0, MemReq=0; exit only via Reset; Pc holds the halt instruction's address.
REQ-027 HALT_OPCODE SHALL never be presented with OpValid=1.
REQ-028 MemValid outside WAIT, Start outside IDLE, and BranchEn outside the handshake SHALL be ignored.
REQ-029 OpValid SHALL be 0 in every state except ISSUE; Opcode/Operand retain last latched value otherwise.

Reset
REQ-030 On Reset=1 at a clock edge: state=IDLE, Pc=0, instruction register=0, Opcode=0, Operand=0, OpValid=0, MemReq=0, Halted=0, FetchError=0.
REQ-031 Reset mid-operation SHALL abort any outstanding fetch; a MemValid arriving after Reset SHALL be ignored.
REQ-032 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-033 With SEQ_FETCH_TIMEOUT_EN defined: a 4-bit counter clears on entry to WAIT and increments each WAIT cycle without MemValid; on reaching 15 the FSM SHALL go to HALT with Halted=1 and FetchError=1.
REQ-034 Without SEQ_FETCH_TIMEOUT_EN: WAIT SHALL persist indefinitely, no counter exists, and FetchError SHALL be tied to 0.

Verification
REQ-035 Reset, Start=1, memory returns 16'h1ABC one cycle after MemReq -> MemAddr=0, then OpValid=1, Opcode=4'h1, Operand=12'hABC, Pc=0; next MemReq has MemAddr=1.
REQ-036 In ISSUE hold Stall=1 for 5 cycles -> OpValid, Opcode, Operand, Pc unchanged; Stall=0 -> one handshake, Pc increments by exactly 1.
REQ-037 Handshake with BranchEn=1, BranchTarget=8'h40 -> next MemAddr=8'h40; Pc=8'hFF non-branch handshake -> next MemAddr=8'h00.
REQ-038 Memory returns 16'hF000 -> Halted=1, OpValid never asserts, MemReq stays 0 and Start ignored until Reset.
REQ-039 Reset asserted in WAIT, MemValid pulsed the following cycle -> state IDLE, OpValid=0, Pc=0, no instruction latched.
REQ-040 With SEQ_FETCH_TIMEOUT_EN, MemValid held 0 after MemReq -> Halted=1 and FetchError=1 after 15 WAIT cycles; without macro -> still in WAIT after 100 cycles, FetchError=0.
